// File: rtl/regfile_wb_if.sv
// Writeback bus between the ALU/LSU writeback paths, the issue stage and the
// register-file write port, including the pending-write scoreboard.
interface regfile_wb_if #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 8
);
  logic            alu_valid;
  logic [AW-1:0]   alu_addr;
  logic [DW-1:0]   alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_data;
  logic            lsu_ready;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic            flush;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [NREG-1:0] busy;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  iss_valid, iss_addr, flush,
    output alu_ready, lsu_ready,
    output we, wr_addr, wr_data, busy
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output iss_valid, iss_addr, flush,
    input  alu_ready, lsu_ready,
    input  we, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU
// writeback, plus the per-register pending-write scoreboard used for hazards.
module regfile_wb_arbiter #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input logic         clk,
  input logic         rst_n,
  regfile_wb_if.slave bus
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  grant_e          last_grant;
  logic            alu_xfer;
  logic            lsu_xfer;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] busy_next;

  // On a tie the requester that did not win most recently gets the port.
  always_comb begin
    bus.alu_ready = rst_n & bus.alu_valid & (~bus.lsu_valid | (last_grant == GNT_LSU));
    bus.lsu_ready = rst_n & bus.lsu_valid & (~bus.alu_valid | (last_grant == GNT_ALU));
  end

  assign alu_xfer = bus.alu_valid & bus.alu_ready;
  assign lsu_xfer = bus.lsu_valid & bus.lsu_ready;

  always_comb begin
    win_addr = bus.lsu_addr;
    win_data = bus.lsu_data;
    if (alu_xfer) begin
      win_addr = bus.alu_addr;
      win_data = bus.alu_data;
    end
  end

  // Issue set beats commit clear on the same register: a newer writer is pending.
  always_comb begin
    busy_next = bus.busy;
    if (bus.we)
      busy_next[bus.wr_addr] = 1'b0;
    if (bus.iss_valid)
      busy_next[bus.iss_addr] = 1'b1;
    if (bus.flush)
      busy_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= GNT_LSU;
      bus.we      <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= '0;
    end else begin
      bus.we   <= alu_xfer | lsu_xfer;
      bus.busy <= busy_next;
      if (alu_xfer | lsu_xfer) begin
        bus.wr_addr <= win_addr;
        bus.wr_data <= win_data;
        last_grant  <= alu_xfer ? GNT_ALU : GNT_LSU;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the ALU and load/store (LSU) writeback paths of the 16-bit RISC CPU. Each requester uses a valid/ready handshake, and ties are settled by round-robin. The block drives registered `we`/`wr_addr`/`wr_data` into the register file. It also keeps a per-register pending-write scoreboard (`busy`) that decode uses for hazard stalls: set at issue, cleared when the write commits.

## Interface
- `DW`, 16, data width (matches register file word)
- `AW`, 3, register index width
- `NREG`, 8, number of registers (2^AW)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU writeback request
- `alu_addr`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle
- `lsu_valid`  in  1  LSU (load) writeback request
- `lsu_addr`  in  AW  load destination register
- `lsu_data`  in  DW  load data
- `lsu_ready`  out  1  LSU request accepted this cycle
- `iss_valid`  in  1  issue stage dispatched an instruction that writes a register
- `iss_addr`  in  AW  destination of the issued instruction
- `flush`  in  1  pipeline flush, synchronous
- `we`  out  1  register-file write enable
- `wr_addr`  out  AW  register-file write index
- `wr_data`  out  DW  register-file write data
- `busy`  out  NREG  bit n = write to register n pending

## Operation
- **Handshake:** a transfer happens in a cycle where `x_valid & x_ready`.
  - `x_ready` is combinational from the valid inputs and the `last_grant` state.
  - At most one ready is high per cycle.
  - `x_ready` is never high while `x_valid` is low.
  - A requester must hold valid, addr and data stable until accepted.
- **Arbitration:**
  - Only one valid: that requester gets ready.
  - Both valid: the requester not granted most recently wins.
  - `last_grant` (0 = ALU, 1 = LSU) updates on every transfer.
  - `last_grant` resets to LSU, so the ALU wins the first tie.
  - Neither valid: no grant, `last_grant` unchanged.
- **Write output:**
  - On a transfer, the winner's addr and data are registered into `wr_addr`/`wr_data`, and `we` = 1 the next cycle.
  - With no transfer, `we` = 0 and `wr_addr`/`wr_data` hold their previous values.
- **Scoreboard:**
  - The edge where `iss_valid` = 1 sets `busy[iss_addr]`.
  - The edge where `we` = 1 clears `busy[wr_addr]`; this is the same edge that writes the register file.
  - Set and clear of the same register on the same edge: set wins (a newer writer is pending).
  - Set and clear of different registers on the same edge: both take effect.
  - A write to a register whose busy bit is already 0 is legal: the register is written and the bit stays 0.
- **Flush:**
  - Clears all `busy` bits on the edge where it is sampled, and takes priority over any `iss_valid` set in that cycle.
  - A registered write already in flight (`we` = 1) still commits.
  - Handshakes in the flush cycle are unaffected; the requesters are responsible for squashing.
- All registers are uniform; register 0 is writable and tracked like any other.

## Timing
- **Reset:** asynchronous. While `rst_n` = 0:
  - `we` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0.
  - `alu_ready` = `lsu_ready` = 0.
  - `last_grant` = LSU.
- **Latency:**
  - Handshake in cycle T gives `we` = 1 in cycle T+1.
  - The register file holds the value and `busy` clears after the edge ending T+1.
  - Read-after-write through the register file is visible in cycle T+2.
- **Throughput:** one write per cycle sustained. With both requesters held valid, grants alternate ALU, LSU, ALU, ...
- **Reset mid-operation:** a pending registered write is discarded (`we` forced to 0) and the scoreboard is cleared. After release, the first tie goes to the ALU.

## Test plan
- Reset, then ALU only: `alu_valid` = 1, addr 3, data 0x1234 for one cycle → `alu_ready` = 1 that cycle; next cycle `we` = 1, `wr_addr` = 3, `wr_data` = 0x1234; `lsu_ready` stays 0.
- Contention: both valid for 4 cycles (ALU r1 0xAAAA, LSU r2 0x5555, each held until accepted, then re-presented) → grant order ALU, LSU, ALU, LSU; `we` = 1 on 4 consecutive cycles with `wr_addr` 1, 2, 1, 2.
- Scoreboard: `iss_valid` r5 → `busy` = 0x20 next cycle; LSU writes r5 → `busy[5]` clears exactly on the edge where `we` = 1 with `wr_addr` = 5.
- Same-edge set/clear: `we` committing r4 while `iss_valid` r4 → `busy[4]` remains 1; with `iss_addr` = 6 instead → `busy[4]` = 0 and `busy[6]` = 1.
- Flush: `busy` = 0xFF, `flush` = 1 together with `iss_valid` r0 while `we` = 1 for r7 → `busy` = 0x00 next cycle; r7 is written in the register file.
- Async reset asserted the cycle after a handshake → `we` drops to 0 immediately with no register-file write; after release, a tie grants ALU first.
